// File: rtl/instruction_assembler_pkg.sv
// Shared RV32 R-type field layout, loader state encoding and the field packer.
package instruction_assembler_pkg;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    localparam int OPCODE_W = 7;
    localparam int REG_W    = 5;
    localparam int FUNCT3_W = 3;
    localparam int FUNCT7_W = 7;

    localparam logic [6:0] OPCODE_R = 7'h33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Purely positional packing; no field is altered.
    function automatic logic [31:0] pack_rtype(
        input logic [FUNCT7_W-1:0] funct7,
        input logic [REG_W-1:0]    rs2,
        input logic [REG_W-1:0]    rs1,
        input logic [FUNCT3_W-1:0] funct3,
        input logic [REG_W-1:0]    rd,
        input logic [OPCODE_W-1:0] opcode
    );
        logic [31:0] word;
        word = 32'h0000_0000;
        word[FUNCT7_LSB +: FUNCT7_W] = funct7;
        word[RS2_LSB    +: REG_W]    = rs2;
        word[RS1_LSB    +: REG_W]    = rs1;
        word[FUNCT3_LSB +: FUNCT3_W] = funct3;
        word[RD_LSB     +: REG_W]    = rd;
        word[OPCODE_LSB +: OPCODE_W] = opcode;
        return word;
    endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry, 32-bit synchronous FIFO with registered full/empty status.
module instr_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    logic [31:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        push_ok_s;
    logic        pop_ok_s;

    assign full_o    = (count_q == 2'd2);
    assign empty_o   = (count_q == 2'd0);
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= 32'h0000_0000;
            mem_q[1] <= 32'h0000_0000;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instruction_assembler.sv
// Program loader: packs R-type field tuples and streams them to instruction memory.
// Optional OPCODE_CHECK_EN drops tuples whose opcode[1:0] != 2'b11 and flags illegal_op.
module instruction_assembler
    import instruction_assembler_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count,
`ifdef OPCODE_CHECK_EN
    output logic              illegal_op,
`endif
    output logic              overflow
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wc_q, wc_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [31:0]       fifo_head_s;
    logic              start_s;
    logic              accept_s;
    logic              legal_s;
    logic              push_s;
    logic              pop_s;
    logic              hit_max_s;
    logic              last_s;

    assign start_s   = (state_q == ST_IDLE) && start;
    assign in_ready  = (state_q == ST_LOAD) && !fifo_full_s;
    assign accept_s  = in_valid && in_ready;
    assign push_s    = accept_s && legal_s;
    assign mem_we    = busy_q && !fifo_empty_s;
    assign pop_s     = mem_we && mem_ready;
    assign hit_max_s = (acc_q == CNT_W'(MAX_WORDS - 1));
    assign last_s    = in_last || hit_max_s;

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = fifo_head_s;
    assign word_count = wc_q;
    assign overflow   = ovf_q;

    instr_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (pack_rtype(funct7, rs2, rs1, funct3, rd, opcode)),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Session sequencing with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept_s && last_s) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Address, written-word count, accepted-tuple count and overflow flag.
    always_comb begin
        addr_d = addr_q;
        wc_d   = wc_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (start_s) begin
            addr_d = {base_addr[ADDR_W-1:2], 2'b00};
            wc_d   = {ADDR_W{1'b0}};
            acc_d  = {CNT_W{1'b0}};
            ovf_d  = 1'b0;
        end else begin
            if (pop_s) begin
                addr_d = addr_q + ADDR_W'(3'd4);
                wc_d   = wc_q + ADDR_W'(1'b1);
            end else begin
                addr_d = addr_q;
                wc_d   = wc_q;
            end
            if (accept_s) begin
                acc_d = acc_q + CNT_W'(1'b1);
                ovf_d = ovf_q | (hit_max_s & ~in_last);
            end else begin
                acc_d = acc_q;
                ovf_d = ovf_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= {ADDR_W{1'b0}};
            wc_q   <= {ADDR_W{1'b0}};
            acc_q  <= {CNT_W{1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wc_q   <= wc_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef OPCODE_CHECK_EN
    logic illegal_q, illegal_d;

    assign legal_s    = (opcode[1:0] == OPCODE_R[1:0]);
    assign illegal_op = illegal_q;

    // Sticky flag for tuples accepted but dropped.
    always_comb begin
        illegal_d = illegal_q;
        if (start_s) begin
            illegal_d = 1'b0;
        end else if (accept_s && !legal_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Illegal-opcode flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign legal_s = 1'b1;
`endif

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler: vector table of single-word sessions plus
// hand-written stall, wrap, overflow, mid-session reset and (optional) opcode-check sequences.
`timescale 1ns/1ps
module tb_instruction_assembler;
    import instruction_assembler_pkg::*;

    localparam int ADDR_W = 8;
    localparam int MAXW   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [6:0]        opcode = 7'h00;
    logic [4:0]        rd = 5'h00;
    logic [2:0]        funct3 = 3'h0;
    logic [4:0]        rs1 = 5'h00;
    logic [4:0]        rs2 = 5'h00;
    logic [6:0]        funct7 = 7'h00;
    logic              mem_we;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] word_count;
    logic              overflow;
`ifdef OPCODE_CHECK_EN
    logic              illegal_op;
`endif

    instruction_assembler #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct7     (funct7),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
`ifdef OPCODE_CHECK_EN
        .illegal_op (illegal_op),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;
    int done_cnt = 0;

    logic [31:0]       exp_data_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    logic              prev_stall = 1'b0;
    logic              prev_done  = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = 8'h00;
    logic [31:0]       prev_data  = 32'h0;

    typedef struct {
        logic [6:0]  f7;
        logic [4:0]  r2;
        logic [4:0]  r1;
        logic [2:0]  f3;
        logic [4:0]  d;
        logic [6:0]  op;
        logic [7:0]  base;
        logic [7:0]  ea;
        logic [31:0] ew;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write scoreboard, stall stability and done-width monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_addr_stable", 32'(mem_addr), 32'(prev_addr));
                chk("stall_data_stable", mem_wdata, prev_data);
            end
            if (mem_we && mem_ready) begin
                writes <= writes + 1;
                if (exp_data_q.size() == 0) begin
                    chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    chk("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                    chk("wr_data", mem_wdata, exp_data_q.pop_front());
                end
            end
            if (done && prev_done) chk("done_one_cycle", 32'(done), 32'h0);
            if (done) done_cnt <= done_cnt + 1;
            prev_stall <= mem_we && !mem_ready;
            prev_addr  <= mem_addr;
            prev_data  <= mem_wdata;
            prev_done  <= done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(w);
    endtask

    task automatic set_tuple(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                             input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        funct7 = f7; rs2 = r2; rs1 = r1; funct3 = f3; rd = d; opcode = op;
    endtask

    task automatic push_tuple(input logic last);
        bit ok;
        ok = 1'b0;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("push_accepted", 32'(ok), 32'h1);
    endtask

    task automatic begin_session(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        step();
        start     = 1'b0;
        chk("busy_after_start", 32'(busy), 32'h1);
    endtask

    task automatic wait_done(input int base_cnt);
        for (int i = 0; i < 40 && done_cnt == base_cnt; i++) step();
        chk("done_pulse_count", 32'(done_cnt), 32'(base_cnt + 1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'h0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'h0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
        chk({tag, "_mem_wdata"},  mem_wdata,       32'h0);
        chk({tag, "_busy"},       32'(busy),       32'h0);
        chk({tag, "_done"},       32'(done),       32'h0);
        chk({tag, "_word_count"}, 32'(word_count), 32'h0);
        chk({tag, "_overflow"},   32'(overflow),   32'h0);
    endtask

    task automatic run_one(input vec_t v);
        int dc;
        logic [7:0] end_addr;
        dc = done_cnt;
        end_addr = v.ea + 8'd4;
        expect_write(v.ea, v.ew);
        mem_ready = 1'b1;
        begin_session(v.base);
        chk("in_ready_in_load", 32'(in_ready), 32'h1);
        chk("overflow_cleared", 32'(overflow), 32'h0);
        set_tuple(v.f7, v.r2, v.r1, v.f3, v.d, v.op);
        push_tuple(1'b1);
        chk("in_ready_after_last", 32'(in_ready), 32'h0);
        wait_done(dc);
        chk("vec_word_count", 32'(word_count), 32'h1);
        chk("vec_end_addr", 32'(mem_addr), 32'(end_addr));
        step();
        chk("idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        int dc;
        bit saw_ready;

        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        bit saw_ready;

        vecs[0] = '{7'h00, 5'd2,  5'd1,  3'd0, 5'd3,  OPCODE_R, 8'h10, 8'h10, 32'h002081B3};
        vecs[1] = '{7'h20, 5'd7,  5'd6,  3'd0, 5'd5,  OPCODE_R, 8'h23, 8'h20, 32'h407302B3};
        vecs[2] = '{7'h00, 5'd12, 5'd11, 3'd7, 5'd10, OPCODE_R, 8'hFF, 8'hFC, 32'h00C5F533};
        vecs[3] = '{7'h7F, 5'h1F, 5'h1F, 3'h7, 5'h1F, 7'h7F,    8'h00, 8'h00, 32'hFFFFFFFF};
        vecs[4] = '{7'h55, 5'h0A, 5'h15, 3'd5, 5'h0A, 7'h2B,    8'h82, 8'h80, 32'hAAAAD52B};
        vecs[5] = '{7'h00, 5'd0,  5'd0,  3'd0, 5'd1,  7'h13,    8'h41, 8'h40, 32'h00000093};

        #2 rst_n = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("idle_ignores_valid", 32'(in_ready), 32'h0);

        for (int i = 0; i < 6; i++) run_one(vecs[i]);

        // Backpressure: FIFO fills, head held stable across a 5-cycle stall.
        dc = done_cnt;
        mem_ready = 1'b0;
        expect_write(8'h10, 32'h002081B3);
        expect_write(8'h14, 32'h407302B3);
        expect_write(8'h18, 32'h00C5F533);
        begin_session(8'h10);
        set_tuple(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPCODE_R);
        push_tuple(1'b0);
        set_tuple(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, OPCODE_R);
        push_tuple(1'b0);
        chk("in_ready_fifo_full", 32'(in_ready), 32'h0);
        chk("mem_we_pending", 32'(mem_we), 32'h1);
        for (int i = 0; i < 5; i++) step();
        chk("stall_word_count", 32'(word_count), 32'h0);
        mem_ready = 1'b1;
        set_tuple(7'h00, 5'd12, 5'd11, 3'd7, 5'd10, OPCODE_R);
        push_tuple(1'b1);
        wait_done(dc);
        chk("stall_word_count_end", 32'(word_count), 32'h3);

        // Address wrap from 0xFC.
        dc = done_cnt;
        expect_write(8'hFC, 32'h002081B3);
        expect_write(8'h00, 32'h407302B3);
        begin_session(8'hFC);
        set_tuple(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPCODE_R);
        push_tuple(1'b0);
        set_tuple(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, OPCODE_R);
        push_tuple(1'b1);
        wait_done(dc);
        chk("wrap_word_count", 32'(word_count), 32'h2);
        chk("wrap_end_addr", 32'(mem_addr), 32'h04);

        // MAX_WORDS reached without in_last.
        dc = done_cnt;
        for (int i = 0; i < 4; i++) expect_write(8'h30 + 8'(4 * i), 32'h00000093 + 32'(i << 7));
        begin_session(8'h30);
        for (int i = 0; i < 4; i++) begin
            set_tuple(7'h00, 5'd0, 5'd0, 3'd0, 5'(i + 1), 7'h13);
            push_tuple(1'b0);
        end
        saw_ready = 1'b0;
        set_tuple(7'h00, 5'd0, 5'd0, 3'd0, 5'd9, 7'h13);
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) saw_ready = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("ovf_no_more_accept", 32'(saw_ready), 32'h0);
        chk("ovf_done_count", 32'(done_cnt), 32'(dc + 1));
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_word_count", 32'(word_count), 32'h4);
        chk("ovf_in_ready_idle", 32'(in_ready), 32'h0);

        // New session clears overflow.
        dc = done_cnt;
        expect_write(8'h50, 32'h002081B3);
        begin_session(8'h50);
        chk("ovf_cleared_on_start", 32'(overflow), 32'h0);
        set_tuple(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPCODE_R);
        push_tuple(1'b1);
        wait_done(dc);

        // Reset mid-session after one of three words written.
        dc = done_cnt;
        mem_ready = 1'b0;
        expect_write(8'h40, 32'h002081B3);
        begin_session(8'h40);
        set_tuple(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPCODE_R);
        push_tuple(1'b0);
        set_tuple(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, OPCODE_R);
        push_tuple(1'b0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        set_tuple(7'h00, 5'd12, 5'd11, 3'd7, 5'd10, OPCODE_R);
        push_tuple(1'b0);
        chk("pre_reset_word_count", 32'(word_count), 32'h1);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("no_done_after_abort", 32'(done_cnt), 32'(dc));
        chk("pending_after_abort", 32'(exp_data_q.size()), 32'h0);

        dc = done_cnt;
        mem_ready = 1'b1;
        expect_write(8'h08, 32'h407302B3);
        begin_session(8'h09);
        set_tuple(7'h20, 5'd7, 5'd6, 3'd0, 5'd5, OPCODE_R);
        push_tuple(1'b1);
        wait_done(dc);
        chk("post_reset_word_count", 32'(word_count), 32'h1);

`ifdef OPCODE_CHECK_EN
        // Illegal opcode dropped, next word lands at the unadvanced address.
        dc = done_cnt;
        expect_write(8'h20, 32'h002081B3);
        begin_session(8'h20);
        chk("illegal_clear_on_start", 32'(illegal_op), 32'h0);
        set_tuple(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h30);
        push_tuple(1'b0);
        chk("illegal_flag", 32'(illegal_op), 32'h1);
        chk("illegal_no_write", 32'(mem_we), 32'h0);
        set_tuple(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPCODE_R);
        push_tuple(1'b1);
        wait_done(dc);
        chk("illegal_word_count", 32'(word_count), 32'h1);
        chk("illegal_sticky", 32'(illegal_op), 32'h1);
`endif

        step();
        chk("all_writes_seen", 32'(exp_data_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_assembler.md
Name: instruction_assembler

Overview:
- Inverse of the field decoder: packs RV32 R-format fields (opcode, rd, funct3, rs1, rs2, funct7) into 32-bit instruction words.
- Streams the packed words into instruction memory at sequential byte addresses.
- Used as the program loader: a testbench or boot sequencer feeds field tuples, and the block writes the program image before the core is released.
- Internal 2-entry FIFO decouples the field producer from memory-port backpressure.

Parameters:
- ADDR_W, 8, width of the instruction-memory byte address. Addresses wrap modulo 2^ADDR_W.
- MAX_WORDS, 64, maximum words per load session. Reaching it forces end of session.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a load session; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address; captured on start. Bits [1:0] are forced to 0.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  block can accept a tuple.
- in_last  in  1  tuple is the final instruction of the session.
- opcode  in  7  instruction bits [6:0].
- rd  in  5  instruction bits [11:7].
- funct3  in  3  instruction bits [14:12].
- rs1  in  5  instruction bits [19:15].
- rs2  in  5  instruction bits [24:20].
- funct7  in  7  instruction bits [31:25].
- mem_we  out  1  write request. High whenever the FIFO is non-empty in LOAD or DRAIN.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  byte address of the current write.
- mem_wdata  out  32  packed word at the FIFO head.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  one-cycle pulse when the session completes.
- word_count  out  ADDR_W  number of words written in the current or last session.
- overflow  out  1  sticky flag: session ended by MAX_WORDS rather than in_last. Cleared on start.

Behaviour:
- Reset (async, rst_n low): state=IDLE, FIFO flushed.
  - All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, word_count, overflow.
  - Reset asserted mid-session aborts the session. Buffered words are discarded and no done pulse is issued.
- Packing: word = {funct7, rs2, rs1, rd... } in field order {funct7, rs2, rs1, funct3, rd, opcode}. Purely positional, no field modification.
- State IDLE:
  - in_ready=0, mem_we=0.
  - start=1 → LOAD; mem_addr <= {base_addr[ADDR_W-1:2], 2'b00}; word_count <= 0; overflow <= 0.
- State LOAD:
  - in_ready = FIFO not full. A full FIFO with a simultaneous pop still deasserts in_ready (no pass-through).
  - Push occurs on in_valid && in_ready. The word is registered into the FIFO, so mem_we rises no earlier than the next cycle (latency 1).
  - Accepted tuple count reaching MAX_WORDS without in_last: treated as last, overflow <= 1.
  - After the last tuple is accepted → DRAIN.
- State DRAIN:
  - in_ready=0.
  - When the FIFO is empty and no write is pending → DONE.
- State DONE: done=1 for exactly one cycle, then → IDLE.
- Write handshake:
  - A write completes on mem_we && mem_ready.
  - On completion: pop the FIFO, mem_addr += 4 (wrapping modulo 2^ADDR_W), word_count += 1.
  - mem_addr and mem_wdata are held stable while mem_we=1 and mem_ready=0.
- Simultaneous push and pop are legal when the FIFO is not full. Occupancy is unchanged.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.

Optional Feature:
- Macro: OPCODE_CHECK_EN.
- When defined:
  - A tuple with opcode[1:0] != 2'b11 is accepted (handshake completes) but dropped, not pushed.
  - Sticky output illegal_op goes to 1 and clears on start.
  - Dropped tuples still count toward MAX_WORDS, and in_last on a dropped tuple still ends the session.
- When undefined: all opcodes are packed and illegal_op does not exist.

Decomposition:
- Shared package holds:
  - R-type field width/offset constants (OPCODE_LSB=0, RD_LSB=7, FUNCT3_LSB=12, RS1_LSB=15, RS2_LSB=20, FUNCT7_LSB=25).
  - A state enum (IDLE, LOAD, DRAIN, DONE).
  - OPCODE_R=7'h33.
- One sub-module, instr_fifo2: 2-entry, 32-bit synchronous FIFO with full/empty flags and async active-low reset.

Test Plan:
- start, base_addr=0x10, one tuple add x3,x1,x2 with last, mem_ready=1 → single write addr 0x10 data 0x002081B3; done one cycle later; word_count=1.
- Two tuples add, then sub x5,x6,x7 (last), mem_ready held 0 for 5 cycles → in_ready drops after 2 pushes; writes 0x002081B3 @0x10, then 0x407302B3 @0x14; address and data stable during stall.
- base_addr=0xFC, 2 words → writes at 0xFC then 0x00 (wrap).
- MAX_WORDS=4 override, 6 tuples with no last → exactly 4 writes, overflow=1, done pulses, in_ready=0 afterwards.
- rst_n pulled low after 1 of 3 words written → all outputs 0 immediately, no done; a new start operates cleanly from IDLE.
- With OPCODE_CHECK_EN defined, tuple with opcode=0x30 → no write, illegal_op=1; the following valid tuple is written at the unadvanced address.
